hotbit_enc: RTL and testbench
=============================

Name: hotbit_enc

Overview:
- Reverse direction of the register-bank one-hot write decoder: accepts an N-line hot-bit vector and serializes it into binary register codes, one code per cycle.
- Lets the bank report or replay which registers were selected, e.g. for read-back or write-enable monitoring.
- Valid/ready handshake on both sides; round-robin service order when several bits are set.

Parameters:
- N, 32, number of hot-bit lines / registers in the bank; code width is $clog2(N).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- hot_in  input  N  hot-bit vector, bit i selects register i
- in_valid  input  1  hot_in is valid
- in_ready  output  1  block can accept a vector
- reg_cod  output  $clog2(N)  binary register code
- cod_valid  output  1  reg_cod is valid
- cod_ready  input  1  consumer accepts reg_cod
- cod_last  output  1  reg_cod is the final code of the current vector
- err  output  1  one-cycle pulse when a vector is rejected (strict mode only)

Behaviour:
- Reset (async assert, sync-to-clk release):
  - pending=0, rr_ptr=0, reg_cod=0, cod_valid=0, cod_last=0, err=0.
  - in_ready=1 one cycle after rst_n rises, then per state.
- State IDLE (pending==0): in_ready=1.
  - in_valid&&in_ready at edge k loads pending=hot_in and goes to DRAIN.
  - A zero vector is accepted, produces no code, and stays in IDLE.
- State DRAIN (pending!=0): in_ready=0.
  - Output slot is free when !cod_valid || cod_ready.
  - Each cycle the slot is free, select the first set bit of pending searching from rr_ptr upward, wrapping at N-1 to 0.
  - Load reg_cod=index and cod_valid=1. Set cod_last=1 iff no other pending bit remains.
  - Clear that bit and set rr_ptr=(index+1) mod N.
  - When the last bit is cleared, return to IDLE; in_ready=1 on the following cycle.
- Latency: vector accepted at edge k, first code valid after edge k+1. Throughput is one code per cycle while cod_ready=1.
- Output hold: when cod_valid && !cod_ready, reg_cod, cod_last and cod_valid hold stable; pending and rr_ptr do not change.
- cod_valid clears on a handshake with no new code to load.
- rr_ptr persists across vectors and is only reset by rst_n.
- Overlap: a new vector can be accepted while the previous vector's last code is still waiting on cod_ready.
- Reset mid-DRAIN: all pending codes are discarded immediately and outputs go to reset values.

Optional Feature:
- HOTBIT_STRICT_EN defined:
  - A vector with popcount != 1 (including zero) is accepted but discarded.
  - err pulses high for one cycle after the accept edge; no codes are emitted.
  - One-hot vectors produce exactly one code with cod_last=1.
- HOTBIT_STRICT_EN undefined:
  - Multi-hot vectors are serialized as described above.
  - err is tied 0.

Decomposition:
- Shared package hotbit_pkg: localparam for code width (CW=$clog2(N)), typedef enum {IDLE, DRAIN} hotbit_state_t, and function popcount for the strict check.
- One natural sub-module, rr_pick: combinational round-robin first-set-bit finder.
  - Inputs: vector, start pointer.
  - Outputs: index, found, remaining-after-clear vector.
  - Instantiated once inside hotbit_enc.

Test Plan (N=32, cod_ready=1 unless stated):
- Single bit: hot_in=32'h0000_0040 -> one code reg_cod=6, cod_last=1, one cycle after accept; rr_ptr becomes 7.
- Multi-hot from reset: hot_in=32'h0000_0044 -> reg_cod=2 (last=0), then 6 (last=1) on consecutive cycles; in_ready=0 during drain.
- Wrap-around (rr_ptr=7 after test 1): hot_in=32'h8000_0008 -> reg_cod=31 then 3; rr_ptr ends at 4.
- Backpressure: hot_in=32'h0000_0044 with cod_ready=0 for 3 cycles -> reg_cod holds 2 with cod_valid=1; after cod_ready=1, codes 2 then 6 follow.
- Reset mid-drain: hot_in=32'hFFFF_FFFF, rst_n low after 3 codes -> cod_valid=0 immediately; after release only a new vector produces output.
- Strict (HOTBIT_STRICT_EN): hot_in=32'h0000_0044 -> err=1 for one cycle, no cod_valid; hot_in=32'h0000_0004 -> reg_cod=2, cod_last=1, err=0.

Source files
------------

// File: rtl/hotbit_pkg.sv
// -----------------------------------------------------------------------------
// hotbit_pkg
//
// Shared definitions for the hot-bit encoder (hotbit_enc) and its round-robin
// picker (rr_pick).
//
// Contents:
//   HOTBIT_N        default number of hot-bit lines / registers in the bank
//   CW              binary code width for the default bank size
//   HOTBIT_MAX_N    widest vector the popcount helper handles
//   hotbit_state_t  encoder FSM states (IDLE: nothing pending, DRAIN: codes left)
//   popcount()      number of set bits, used by the strict one-hot check
// -----------------------------------------------------------------------------
package hotbit_pkg;

    localparam int HOTBIT_N     = 32;
    localparam int CW           = $clog2(HOTBIT_N);
    localparam int HOTBIT_MAX_N = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } hotbit_state_t;

    // Callers zero-extend their vector to HOTBIT_MAX_N bits; the extra zeros
    // do not change the count.
    function automatic int unsigned popcount(input logic [HOTBIT_MAX_N-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < HOTBIT_MAX_N; i++) begin
            cnt += {31'b0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/hotbit_enc_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin first-set-bit finder. Searches vec_i starting at
// bit start_i and moving upward, wrapping from N-1 back to 0, and reports the
// first set bit it meets.
//
// Ports:
//   vec_i    [N-1:0]          vector to search
//   start_i  [$clog2(N)-1:0]  first bit position to look at
//   idx_o    [$clog2(N)-1:0]  index of the selected bit (0 when none found)
//   found_o                   at least one bit of vec_i is set
//   rest_o   [N-1:0]          vec_i with the selected bit cleared
// -----------------------------------------------------------------------------
module rr_pick
    import hotbit_pkg::*;
#(
    parameter int N = HOTBIT_N
) (
    input  logic [N-1:0]         vec_i,
    input  logic [$clog2(N)-1:0] start_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 found_o,
    output logic [N-1:0]         rest_o
);

    localparam int W = $clog2(N);

    // Walk every offset from the start pointer; the first hit wins and later
    // hits are ignored. The modulo-N wrap is done on an int so that bank
    // sizes that are not a power of two still wrap at N-1.
    always_comb begin
        int          sum;
        logic [W-1:0] pos;
        idx_o   = '0;
        found_o = 1'b0;
        sum     = 0;
        pos     = '0;
        for (int off = 0; off < N; off++) begin
            sum = int'(start_i) + off;
            if (sum >= N) begin
                sum = sum - N;
            end
            pos = W'(sum);
            if (!found_o && vec_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
        rest_o = vec_i;
        if (found_o) begin
            rest_o[idx_o] = 1'b0;
        end
    end

endmodule

// File: rtl/hotbit_enc.sv
// -----------------------------------------------------------------------------
// hotbit_enc
//
// Hot-bit to binary register-code serializer. Accepts an N-line hot-bit
// vector (bit i selects register i) and emits the binary index of every set
// bit, one code per cycle, in round-robin order. The round-robin pointer
// continues from where the previous vector left off and is cleared only by
// reset.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   hot_in     [N-1:0] hot-bit vector
//   in_valid   hot_in is valid
//   in_ready   encoder can accept a vector (high while nothing is pending)
//   reg_cod    [$clog2(N)-1:0] binary register code
//   cod_valid  reg_cod is valid
//   cod_ready  consumer accepts reg_cod
//   cod_last   reg_cod is the final code of its vector
//   err        one-cycle pulse when a vector is rejected (strict build only)
//
// Build option:
//   HOTBIT_STRICT_EN  when defined, only one-hot vectors are serialized; any
//                     other vector (including zero) is accepted, discarded and
//                     flagged with an err pulse. When undefined, multi-hot
//                     vectors are serialized and err is tied low.
// -----------------------------------------------------------------------------
module hotbit_enc
    import hotbit_pkg::*;
#(
    parameter int N = HOTBIT_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         hot_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [$clog2(N)-1:0] reg_cod,
    output logic                 cod_valid,
    input  logic                 cod_ready,
    output logic                 cod_last,
    output logic                 err
);

    localparam int W = $clog2(N);

    hotbit_state_t state_q;
    logic [N-1:0]  pending_q;
    logic [N-1:0]  pending_d;
    logic [W-1:0]  rrPtr_q;
    logic [W-1:0]  rrPtr_d;
    logic [W-1:0]  regCod_q;
    logic          codValid_q;
    logic          codLast_q;
    logic          inReady_q;
    logic [W-1:0]  pickIdx;
    logic          pickFound;
    logic          slotFree;

    rr_pick #(
        .N (N)
    ) uPick (
        .vec_i   (pending_q),
        .start_i (rrPtr_q),
        .idx_o   (pickIdx),
        .found_o (pickFound),
        .rest_o  (pending_d)
    );

    // The pointer moves just past the code being issued so the next search
    // starts at the following register.
    assign rrPtr_d  = (pickIdx == W'(N - 1)) ? '0 : pickIdx + 1'b1;

    // A new code may be loaded when the output register is empty or its
    // current code is being taken this cycle.
    assign slotFree = !codValid_q || cod_ready;

`ifdef HOTBIT_STRICT_EN
    logic                    err_q;
    logic [HOTBIT_MAX_N-1:0] hotExt;

    assign hotExt = HOTBIT_MAX_N'(hot_in);
    assign err    = err_q;
`else
    assign err    = 1'b0;
`endif

    // Encoder FSM. IDLE accepts a vector and drains the last code of the
    // previous vector; DRAIN issues one code per free output slot. Going back
    // to IDLE as soon as the final code is loaded lets the next vector be
    // accepted while that code still waits on cod_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            rrPtr_q    <= '0;
            regCod_q   <= '0;
            codValid_q <= 1'b0;
            codLast_q  <= 1'b0;
            inReady_q  <= 1'b0;
`ifdef HOTBIT_STRICT_EN
            err_q      <= 1'b0;
`endif
        end else begin
`ifdef HOTBIT_STRICT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    inReady_q <= 1'b1;
                    if (codValid_q && cod_ready) begin
                        codValid_q <= 1'b0;
                        codLast_q  <= 1'b0;
                    end
                    // inReady_q is low for the first cycle after reset, so
                    // nothing is accepted before the block reports ready.
                    if (in_valid && inReady_q) begin
`ifdef HOTBIT_STRICT_EN
                        if (popcount(hotExt) != 1) begin
                            err_q <= 1'b1;
                        end else begin
                            pending_q <= hot_in;
                            state_q   <= DRAIN;
                            inReady_q <= 1'b0;
                        end
`else
                        if (hot_in != '0) begin
                            pending_q <= hot_in;
                            state_q   <= DRAIN;
                            inReady_q <= 1'b0;
                        end
`endif
                    end
                end
                DRAIN: begin
                    if (!pickFound) begin
                        state_q   <= IDLE;
                        inReady_q <= 1'b1;
                    end else if (slotFree) begin
                        regCod_q   <= pickIdx;
                        codValid_q <= 1'b1;
                        codLast_q  <= (pending_d == '0);
                        pending_q  <= pending_d;
                        rrPtr_q    <= rrPtr_d;
                        if (pending_d == '0) begin
                            state_q   <= IDLE;
                            inReady_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    inReady_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign reg_cod   = regCod_q;
    assign cod_valid = codValid_q;
    assign cod_last  = codLast_q;

endmodule

// File: tb/tb_hotbit_enc.sv
// -----------------------------------------------------------------------------
// tb_hotbit_enc
//
// Self-checking bench for hotbit_enc (N=32). Directed vectors push their
// hand-computed codes into an expectation queue; a monitor pops and compares
// on every output handshake. Direct checks cover reset values, first-code
// latency, in_ready, output hold under backpressure and reset mid-drain.
// The strict-mode sequence is selected with HOTBIT_STRICT_EN.
// -----------------------------------------------------------------------------
module tb_hotbit_enc;

    typedef struct packed {
        logic [4:0] code;
        logic       last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] hot_in;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  reg_cod;
    logic        cod_valid;
    logic        cod_ready;
    logic        cod_last;
    logic        err;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    hotbit_enc #(
        .N (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hot_in    (hot_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reg_cod   (reg_cod),
        .cod_valid (cod_valid),
        .cod_ready (cod_ready),
        .cod_last  (cod_last),
        .err       (err)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a bounded wait is ever missed.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [4:0] code, input logic last);
        exp_t e;
        e.code = code;
        e.last = last;
        expQ.push_back(e);
    endtask

    // Present one vector and hold it until the accepting edge has passed.
    task automatic applyStimulus(input logic [31:0] v);
        int waitCnt;
        waitCnt = 0;
        while (!in_ready && waitCnt < 100) begin
            tick();
            waitCnt++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout got 0 expected 1 at %0t", $time);
            return;
        end
        hot_in   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        hot_in   = '0;
    endtask

    // Wait until every expected code has been seen and the output is empty.
    task automatic waitDrain();
        int waitCnt;
        waitCnt = 0;
        while ((expQ.size() != 0 || cod_valid) && waitCnt < 200) begin
            tick();
            waitCnt++;
        end
        if (expQ.size() != 0 || cod_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout pending %0d expected 0", expQ.size());
        end
    endtask

    // Reset pulse with checks on the reset values and on in_ready rising one
    // cycle after release.
    task automatic doReset();
        rst_n     = 1'b0;
        cod_ready = 1'b1;
        #1;
        checkOutput("rst_cod_valid", 32'(cod_valid), 32'd0);
        checkOutput("rst_reg_cod", 32'(reg_cod), 32'd0);
        checkOutput("rst_cod_last", 32'(cod_last), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Scoreboard monitor: every handshake seen on the falling edge must match
    // the oldest expected code.
    always @(negedge clk) begin
        if (rst_n && cod_valid && cod_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_code got %0d expected none", reg_cod);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sb_code", 32'(reg_cod), 32'(e.code));
                checkOutput("sb_last", 32'(cod_last), 32'(e.last));
            end
        end
    end

    // Directed sequence; round-robin pointer values noted per step.
    initial begin
        rst_n     = 1'b0;
        hot_in    = '0;
        in_valid  = 1'b0;
        cod_ready = 1'b1;
        tick();
        doReset();

        // Single bit from rr=0: code 6 one cycle after accept, rr -> 7.
        pushExp(5'd6, 1'b1);
        applyStimulus(32'h0000_0040);
        checkOutput("lat_before", 32'(cod_valid), 32'd0);
        tick();
        checkOutput("lat_valid", 32'(cod_valid), 32'd1);
        checkOutput("lat_code", 32'(reg_cod), 32'd6);
        checkOutput("lat_last", 32'(cod_last), 32'd1);
        waitDrain();

`ifndef HOTBIT_STRICT_EN
        // Multi-hot, rr=7: search wraps to 2, then 6; rr -> 7.
        pushExp(5'd2, 1'b0);
        pushExp(5'd6, 1'b1);
        applyStimulus(32'h0000_0044);
        checkOutput("drain_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("drain_in_ready2", 32'(in_ready), 32'd0);
        waitDrain();
        checkOutput("err_tied", 32'(err), 32'd0);

        // Wrap-around, rr=7: 31 then 3; rr -> 4.
        pushExp(5'd31, 1'b0);
        pushExp(5'd3, 1'b1);
        applyStimulus(32'h8000_0008);
        waitDrain();

        // Pointer persists, rr=4: 6 first, then wraps to 2; rr -> 3.
        pushExp(5'd6, 1'b0);
        pushExp(5'd2, 1'b1);
        applyStimulus(32'h0000_0044);
        waitDrain();

        // Backpressure after reset, rr=0: code 2 held three cycles.
        doReset();
        cod_ready = 1'b0;
        pushExp(5'd2, 1'b0);
        pushExp(5'd6, 1'b1);
        applyStimulus(32'h0000_0044);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_valid", 32'(cod_valid), 32'd1);
            checkOutput("hold_code", 32'(reg_cod), 32'd2);
            checkOutput("hold_last", 32'(cod_last), 32'd0);
        end
        cod_ready = 1'b1;
        waitDrain();

        // Zero vector is accepted and produces nothing.
        applyStimulus(32'h0000_0000);
        checkOutput("zero_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("zero_valid", 32'(cod_valid), 32'd0);

        // Reset mid-drain, rr=7: codes 7, 8, 9 taken, then reset while 10 waits.
        pushExp(5'd7, 1'b0);
        pushExp(5'd8, 1'b0);
        pushExp(5'd9, 1'b0);
        applyStimulus(32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        checkOutput("pre_rst_code", 32'(reg_cod), 32'd10);
        cod_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(cod_valid), 32'd0);
        checkOutput("mid_rst_code", 32'(reg_cod), 32'd0);
        checkOutput("sb_after_rst", 32'(expQ.size()), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        cod_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_rst_quiet", 32'(cod_valid), 32'd0);
        end
        // rr back to 0: bit 0 gives code 0; rr -> 1.
        pushExp(5'd0, 1'b1);
        applyStimulus(32'h0000_0001);
        waitDrain();

        // Overlap, rr=1: code 1 held, next vector (bit 3) accepted meanwhile.
        cod_ready = 1'b0;
        pushExp(5'd1, 1'b1);
        pushExp(5'd3, 1'b1);
        applyStimulus(32'h0000_0002);
        tick();
        checkOutput("ovl_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(32'h0000_0008);
        checkOutput("ovl_hold_code", 32'(reg_cod), 32'd1);
        checkOutput("ovl_hold_valid", 32'(cod_valid), 32'd1);
        cod_ready = 1'b1;
        waitDrain();
`else
        // Strict: multi-hot rejected with one err pulse, no codes.
        applyStimulus(32'h0000_0044);
        checkOutput("strict_err", 32'(err), 32'd1);
        checkOutput("strict_no_code", 32'(cod_valid), 32'd0);
        tick();
        checkOutput("strict_err_pulse", 32'(err), 32'd0);
        checkOutput("strict_no_code2", 32'(cod_valid), 32'd0);

        // Strict: zero vector rejected too.
        applyStimulus(32'h0000_0000);
        checkOutput("strict_zero_err", 32'(err), 32'd1);
        tick();
        checkOutput("strict_zero_pulse", 32'(err), 32'd0);

        // Strict: one-hot bit 2 from rr=7 gives code 2, last.
        pushExp(5'd2, 1'b1);
        applyStimulus(32'h0000_0004);
        checkOutput("strict_ok_err", 32'(err), 32'd0);
        waitDrain();

        // Reset while a held code waits: output cleared immediately.
        cod_ready = 1'b0;
        applyStimulus(32'h0000_0010);
        tick();
        checkOutput("strict_held_code", 32'(reg_cod), 32'd4);
        rst_n = 1'b0;
        #1;
        checkOutput("strict_rst_valid", 32'(cod_valid), 32'd0);
        tick();
        rst_n     = 1'b1;
        cod_ready = 1'b1;
        tick();
        tick();
        checkOutput("strict_post_rst", 32'(cod_valid), 32'd0);
`endif

        tick();
        tick();
        checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
